keynsham_bus_fabric: RTL and testbench

//  Parametrised data-bus interconnect for the keynsham SoC: one CPU master, NUM_SLAVES slaves.

---
 rtl/keynsham_bus_fabric.sv | 149 ++++++++++++++
 tb/tb_keynsham_bus_fabric.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keynsham_bus_fabric.sv
// keynsham_bus_fabric: single-master data-bus interconnect.
// Decodes slave address windows, forwards the access to one slave, and returns that
// slave's ack/error/data. Unmapped accesses and silent slaves are answered by the
// fabric with a one-cycle bus error, and the first such error is captured for software.
module keynsham_bus_fabric #(
  parameter int unsigned NUM_SLAVES     = 8,
  parameter int unsigned ADDR_WIDTH     = 30,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASES = '0,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASKS = '0,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TIMEOUT_WIDTH  = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            m_access,
  input  logic [ADDR_WIDTH-1:0]           m_addr,
  output logic [DATA_WIDTH-1:0]           m_data,
  output logic                            m_ack,
  output logic                            m_error,
  output logic [NUM_SLAVES-1:0]           s_cs,
  output logic [NUM_SLAVES-1:0]           s_access,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_data,
  input  logic [NUM_SLAVES-1:0]           s_ack,
  input  logic [NUM_SLAVES-1:0]           s_error,
  output logic                            err_valid,
  output logic                            err_cause,
  output logic [ADDR_WIDTH-1:0]           err_addr,
  input  logic                            err_clear
);

  localparam int unsigned SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam bit          TO_EN = (TIMEOUT_CYCLES != 0);
  // Last wait-cycle count value before the fabric gives up on the slave.
  localparam logic [TIMEOUT_WIDTH-1:0] TO_LIMIT =
    TO_EN ? TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  state_t                   r_state;
  logic [SEL_W-1:0]         r_sel;
  logic [TIMEOUT_WIDTH-1:0] r_cnt;
  logic                     r_err_valid;
  logic                     r_err_cause;
  logic [ADDR_WIDTH-1:0]    r_err_addr;

  logic [NUM_SLAVES-1:0]    w_cs;
  logic                     w_hit;
  logic [SEL_W-1:0]         w_idx;
  logic                     w_sel_ack;
  logic                     w_sel_err;
  logic [DATA_WIDTH-1:0]    w_sel_data;
  logic                     w_wait_ack;
  logic                     w_timeout;
  logic                     w_enter_err;
  logic                     w_enter_cause;

  // Address decode: first (lowest-index) enabled window that matches wins.
  always_comb begin
    w_cs  = '0;
    w_hit = 1'b0;
    w_idx = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (!w_hit &&
          (SLAVE_MASKS[i*ADDR_WIDTH +: ADDR_WIDTH] != '0) &&
          ((m_addr & SLAVE_MASKS[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
           SLAVE_BASES[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
        w_hit   = 1'b1;
        w_idx   = SEL_W'(i);
        w_cs[i] = 1'b1;
      end
    end
  end

  // Response path of the latched slave and the conditions that send the FSM to ERR.
  always_comb begin
    w_sel_ack     = s_ack[r_sel];
    w_sel_err     = s_error[r_sel];
    w_sel_data    = s_data[r_sel*DATA_WIDTH +: DATA_WIDTH];
    w_wait_ack    = (r_state == ST_WAIT) && w_sel_ack;
    w_timeout     = TO_EN && (r_state == ST_WAIT) && !w_sel_ack && (r_cnt == TO_LIMIT);
    w_enter_err   = ((r_state == ST_IDLE) && m_access && !w_hit) || w_timeout;
    w_enter_cause = w_timeout;
  end

  // Master/slave facing outputs; everything is forced quiet while reset is asserted.
  always_comb begin
    s_cs     = rst ? '0 : w_cs;
    s_access = (!rst && m_access && (r_state == ST_IDLE)) ? w_cs : '0;
    m_ack    = !rst && (w_wait_ack || (r_state == ST_ERR));
    m_error  = !rst && ((w_wait_ack && w_sel_err) || (r_state == ST_ERR));
    m_data   = (!rst && w_wait_ack) ? w_sel_data : '0;
  end

  assign err_valid = r_err_valid;
  assign err_cause = r_err_cause;
  assign err_addr  = r_err_addr;

  // Transaction FSM with wait counter and first-error capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_sel       <= '0;
      r_cnt       <= '0;
      r_err_valid <= 1'b0;
      r_err_cause <= 1'b0;
      r_err_addr  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (m_access) begin
            if (w_hit) begin
              r_sel   <= w_idx;
              r_cnt   <= '0;
              r_state <= ST_WAIT;
            end else begin
              r_state <= ST_ERR;
            end
          end
        end
        ST_WAIT: begin
          if (w_sel_ack) begin
            r_state <= ST_IDLE;
          end else if (w_timeout) begin
            r_state <= ST_ERR;
          end else begin
            r_cnt <= r_cnt + TIMEOUT_WIDTH'(1);
          end
        end
        ST_ERR:  r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase

      // A new error beats a coincident clear; otherwise the first capture is kept.
      if (w_enter_err && (!r_err_valid || err_clear)) begin
        r_err_valid <= 1'b1;
        r_err_cause <= w_enter_cause;
        r_err_addr  <= m_addr;
      end else if (err_clear) begin
        r_err_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_keynsham_bus_fabric.sv
// Bench for keynsham_bus_fabric: transaction-level model with a per-cycle compare process.
module tb_keynsham_bus_fabric;

  localparam int NS = 8;
  localparam int AW = 30;
  localparam int DW = 32;
  localparam int TO = 4;

  localparam logic [NS*AW-1:0] BASES = {
    30'h20000000, 30'h10000000, 30'h0C000000, 30'h08100000,
    30'h08000000, 30'h04000000, 30'h00100000, 30'h00000000};
  localparam logic [NS*AW-1:0] MASKS = {
    30'h3FFFFFFF, 30'h30000000, 30'h00000000, 30'h3FF00000,
    30'h3F000000, 30'h3FF00000, 30'h3FF00000, 30'h3FF00000};

  // Model's own view of the address map, slave 0 first.
  logic [AW-1:0] mb [NS] = '{30'h00000000, 30'h00100000, 30'h04000000, 30'h08000000,
                             30'h08100000, 30'h0C000000, 30'h10000000, 30'h20000000};
  logic [AW-1:0] mm [NS] = '{30'h3FF00000, 30'h3FF00000, 30'h3FF00000, 30'h3F000000,
                             30'h3FF00000, 30'h00000000, 30'h30000000, 30'h3FFFFFFF};

  logic clk = 1'b0;
  logic rst, m_access, err_clear;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic m_ack, m_error, err_valid, err_cause;
  logic [NS-1:0] s_cs, s_access, s_ack, s_error;
  logic [NS*DW-1:0] s_data;
  logic [AW-1:0] err_addr;

  keynsham_bus_fabric #(
    .NUM_SLAVES(NS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .SLAVE_BASES(BASES), .SLAVE_MASKS(MASKS),
    .TIMEOUT_CYCLES(TO), .TIMEOUT_WIDTH(8)
  ) dut (
    .clk(clk), .rst(rst), .m_access(m_access), .m_addr(m_addr), .m_data(m_data),
    .m_ack(m_ack), .m_error(m_error), .s_cs(s_cs), .s_access(s_access), .s_data(s_data),
    .s_ack(s_ack), .s_error(s_error), .err_valid(err_valid), .err_cause(err_cause),
    .err_addr(err_addr), .err_clear(err_clear)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;
  bit noise = 1'b0;
  bit rnd_clr_en = 1'b0;
  bit force0 = 1'b0;

  // Model state: expected master response this cycle, whether the fabric is idle,
  // and the error capture register.
  logic exp_ack = 1'b0, exp_err = 1'b0;
  logic [DW-1:0] exp_data = '0;
  bit mdl_idle = 1'b1;
  logic mv = 1'b0, mc = 1'b0;
  logic [AW-1:0] ma = '0;

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int dec(input logic [AW-1:0] a);
    for (int i = 0; i < NS; i++)
      if (mm[i] != '0 && (a & mm[i]) == mb[i]) return i;
    return -1;
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r < NS) return mb[r] | (AW'($urandom) & ~((mm[r] == '0) ? 30'h3FF00000 : mm[r]));
    return AW'($urandom);
  endfunction

  function automatic bit rnd_clear();
    return rnd_clr_en && ($urandom_range(0, 7) == 0);
  endfunction

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    int k;
    logic [NS-1:0] ecs;
    if (chk_en) begin
      k = dec(m_addr);
      ecs = (rst || k < 0) ? '0 : NS'(1 << k);
      cmp("s_cs", 64'(s_cs), 64'(ecs));
      cmp("s_access", 64'(s_access), 64'((!rst && m_access && mdl_idle) ? ecs : '0));
      cmp("m_ack", 64'(m_ack), 64'(exp_ack));
      cmp("m_error", 64'(m_error), 64'(exp_err));
      cmp("m_data", 64'(m_data), 64'(exp_data));
      cmp("err_valid", 64'(err_valid), 64'(mv));
      cmp("err_cause", 64'(err_cause), 64'(mc));
      cmp("err_addr", 64'(err_addr), 64'(ma));
    end
  end

  // Advance one clock; update the capture model with what the DUT sees at the edge.
  task automatic step(input bit enter, input bit cause, input logic [AW-1:0] a);
    @(posedge clk);
    if (rst) begin
      mv = 1'b0; mc = 1'b0; ma = '0;
    end else if (enter && (!mv || err_clear)) begin
      mv = 1'b1; mc = cause; ma = a;
    end else if (err_clear) begin
      mv = 1'b0;
    end
    #1;
  endtask

  task automatic idle_noise();
    s_ack   = noise ? NS'($urandom) : '0;
    s_error = noise ? NS'($urandom) : '0;
    s_data  = noise ? {$urandom, $urandom, $urandom, $urandom,
                       $urandom, $urandom, $urandom, $urandom} : '0;
  endtask

  task automatic wait_noise(input int k, input int j);
    idle_noise();
    if (k >= 0) s_ack[k] = 1'b0;
    m_access = noise && ($urandom_range(0, 3) == 0);
    if (force0 && j == 1) begin
      s_ack[0] = 1'b1;
      s_data[31:0] = 32'h55;
    end
  endtask

  task automatic quiet();
    exp_ack = 1'b0; exp_err = 1'b0; exp_data = '0;
  endtask

  // One complete master transaction, followed by an idle gap that also delivers late acks.
  task automatic txn(input logic [AW-1:0] a, input int d, input bit serr,
                     input logic [DW-1:0] dat, input bit clr_entry,
                     output int lat, output logic [DW-1:0] c_data,
                     output logic c_err, output logic [NS-1:0] c_sacc);
    int k, j, gap;
    bit done;
    k = dec(a);
    lat = -1; c_data = '0; c_err = 1'b0;
    idle_noise();
    m_access = 1'b1; m_addr = a; mdl_idle = 1'b1; quiet();
    err_clear = clr_entry | rnd_clear();
    @(negedge clk);
    c_sacc = s_access;
    step(k < 0, 1'b0, a);
    mdl_idle = 1'b0;
    j = 1; done = 1'b0;
    while (!done) begin
      wait_noise(k, j);
      quiet();
      err_clear = rnd_clear();
      if (k < 0 || j == TO + 1) begin
        exp_ack = 1'b1; exp_err = 1'b1;
        if (k >= 0 && j == d) s_ack[k] = 1'b1;
        done = 1'b1;
      end else if (j == d) begin
        s_ack[k] = 1'b1; s_data[k*DW +: DW] = dat; s_error[k] = serr;
        exp_ack = 1'b1; exp_err = serr; exp_data = dat;
        done = 1'b1;
      end
      if (done) begin
        @(negedge clk);
        lat = j; c_data = m_data; c_err = m_error;
      end
      step(k >= 0 && !done && j == TO, 1'b1, a);
      j++;
    end
    mdl_idle = 1'b1; m_access = 1'b0; quiet();
    gap = $urandom_range(1, 2);
    while (gap > 0 || (k >= 0 && j <= d)) begin
      idle_noise();
      m_addr = rand_addr();
      if (k >= 0 && j == d) begin
        s_ack[k] = 1'b1; s_data[k*DW +: DW] = dat;
      end
      err_clear = rnd_clear();
      step(1'b0, 1'b0, '0);
      j++;
      if (gap > 0) gap--;
    end
    err_clear = 1'b0;
  endtask

  int lat;
  logic [DW-1:0] cd;
  logic ce;
  logic [NS-1:0] cs;

  initial begin
    rst = 1'b1; m_access = 1'b0; m_addr = '0; err_clear = 1'b0;
    s_ack = '0; s_error = '0; s_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    step(1'b0, 1'b0, '0);
    rst = 1'b0;
    step(1'b0, 1'b0, '0);
    cmp("reset_err_valid", 64'(err_valid), 64'd0);

    // T1 slave 2 read with a 3-cycle slave latency
    txn(30'h04000010, 3, 1'b0, 32'hDEADBEEF, 1'b0, lat, cd, ce, cs);
    cmp("t1_lat", 64'(lat), 64'd3);
    cmp("t1_data", 64'(cd), 64'hDEADBEEF);
    cmp("t1_err", 64'(ce), 64'd0);
    cmp("t1_sacc", 64'(cs), 64'h04);

    // T2 unmapped address answered one cycle later
    txn(30'h3FFFFFFF, 1, 1'b0, '0, 1'b0, lat, cd, ce, cs);
    cmp("t2_lat", 64'(lat), 64'd1);
    cmp("t2_err", 64'(ce), 64'd1);
    cmp("t2_sacc", 64'(cs), 64'h00);
    cmp("t2_valid", 64'(err_valid), 64'd1);
    cmp("t2_cause", 64'(err_cause), 64'd0);
    cmp("t2_addr", 64'(err_addr), 64'h3FFFFFFF);

    // T3 silent slave times out; its ack 10 cycles later is dropped
    err_clear = 1'b1;
    step(1'b0, 1'b0, '0);
    err_clear = 1'b0;
    txn(30'h00000123, 15, 1'b0, 32'h1234, 1'b0, lat, cd, ce, cs);
    cmp("t3_lat", 64'(lat), 64'd5);
    cmp("t3_err", 64'(ce), 64'd1);
    cmp("t3_data", 64'(cd), 64'd0);
    cmp("t3_cause", 64'(err_cause), 64'd1);
    cmp("t3_addr", 64'(err_addr), 64'h123);

    // T4 stray ack from slave 0 while waiting on slave 1
    force0 = 1'b1;
    txn(30'h00100044, 3, 1'b0, 32'hCAFE0001, 1'b0, lat, cd, ce, cs);
    force0 = 1'b0;
    cmp("t4_lat", 64'(lat), 64'd3);
    cmp("t4_data", 64'(cd), 64'hCAFE0001);

    // Overlapping windows resolve to the lower index; disabled slave is unmapped
    txn(30'h08100005, 2, 1'b1, 32'hA5A5A5A5, 1'b0, lat, cd, ce, cs);
    cmp("ovl_sacc", 64'(cs), 64'h08);
    cmp("ovl_err", 64'(ce), 64'd1);

    // T5 later errors do not overwrite; clear coincident with an error captures it
    txn(30'h0C000001, 1, 1'b0, '0, 1'b0, lat, cd, ce, cs);
    cmp("t5_sacc", 64'(cs), 64'h00);
    cmp("t5_keep_addr", 64'(err_addr), 64'h123);
    cmp("t5_keep_cause", 64'(err_cause), 64'd1);
    txn(30'h3FFFFFF0, 1, 1'b0, '0, 1'b1, lat, cd, ce, cs);
    cmp("t5_new_valid", 64'(err_valid), 64'd1);
    cmp("t5_new_addr", 64'(err_addr), 64'h3FFFFFF0);
    cmp("t5_new_cause", 64'(err_cause), 64'd0);

    // T6 reset while waiting; the pending ack arrives in IDLE and is dropped
    m_access = 1'b1; m_addr = 30'h00100008; mdl_idle = 1'b1; quiet();
    step(1'b0, 1'b0, '0);
    m_access = 1'b0; mdl_idle = 1'b0; rst = 1'b1;
    step(1'b0, 1'b0, '0);
    rst = 1'b0; mdl_idle = 1'b1;
    cmp("t6_valid", 64'(err_valid), 64'd0);
    s_ack[1] = 1'b1; s_data[DW +: DW] = 32'h77;
    step(1'b0, 1'b0, '0);
    s_ack = '0; s_data = '0;
    txn(30'h00100008, 2, 1'b0, 32'h600DF00D, 1'b0, lat, cd, ce, cs);
    cmp("t6_lat", 64'(lat), 64'd2);
    cmp("t6_data", 64'(cd), 64'h600DF00D);

    // Randomized traffic with slave noise, protocol-violating strobes and random clears
    noise = 1'b1; rnd_clr_en = 1'b1;
    for (int n = 0; n < 400; n++) begin
      txn(rand_addr(), $urandom_range(1, TO + 4), 1'(($urandom_range(0, 3)) == 0),
          $urandom, 1'b0, lat, cd, ce, cs);
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
